// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus a four-state qualification FSM that debounces a raw button level
// and emits one-cycle rise/fall strobes. Define DEBOUNCE_GLITCH_CNT_EN to add the glitch_cnt port.
module button_debouncer #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       btn_out,
    output logic       rise_pulse,
    output logic       fall_pulse
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 s1_q, s1_d;
    logic                 s2_q, s2_d;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 btn_out_q, btn_out_d;
    logic                 rise_pulse_q, rise_pulse_d;
    logic                 fall_pulse_q, fall_pulse_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            state_q      <= IDLE_LOW;
            cnt_q        <= '0;
            btn_out_q    <= 1'b0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            btn_out_q    <= btn_out_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
        end
    end

    // Only s2_q is trusted downstream; s1_q may still be metastable.
    always_comb begin
        s1_d         = btn_in;
        s2_d         = s1_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        btn_out_d    = btn_out_q;
        rise_pulse_d = 1'b0;
        fall_pulse_d = 1'b0;

        case (state_q)
            IDLE_LOW: begin
                if (s2_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s2_q) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = IDLE_HIGH;
                    btn_out_d    = 1'b1;
                    rise_pulse_d = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s2_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s2_q) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = IDLE_LOW;
                    btn_out_d    = 1'b0;
                    fall_pulse_d = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn_out    = btn_out_q;
    assign rise_pulse = rise_pulse_q;
    assign fall_pulse = fall_pulse_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_q, glitch_cnt_d;
    logic       abort;

    // An abort is a WAIT state seeing the old level again before the count completes.
    always_comb begin
        abort        = ((state_q == WAIT_HIGH) && !s2_q) || ((state_q == WAIT_LOW) && s2_q);
        glitch_cnt_d = glitch_cnt_q;
        if (abort && (glitch_cnt_q != 8'hFF)) begin
            glitch_cnt_d = glitch_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_cnt_q <= 8'd0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer, scored against a run-length model
// of the debounce rules (input seen two edges late, level flips after STABLE_CYCLES differing samples).
module tb_button_debouncer;

    localparam int SC = 4;
    localparam int CW = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_in;
    logic       btn_out;
    logic       rise_pulse;
    logic       fall_pulse;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    button_debouncer #(
        .STABLE_CYCLES(SC),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .btn_out   (btn_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    always #4 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int riseSeen = 0;
    int fallSeen = 0;

    // Reference model state: delay line of raw samples plus a run-length of differing samples.
    logic mDelay1, mDelay2, mLevel, mRise, mFall;
    int   mRun, mGlitch;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mDelay1 = 1'b0;
        mDelay2 = 1'b0;
        mLevel  = 1'b0;
        mRise   = 1'b0;
        mFall   = 1'b0;
        mRun    = 0;
        mGlitch = 0;
    endtask

    task automatic modelStep();
        logic seen;
        if (!reset) return;
        seen    = mDelay2;
        mDelay2 = mDelay1;
        mDelay1 = btn_in;
        mRise   = 1'b0;
        mFall   = 1'b0;
        if (seen != mLevel) begin
            mRun++;
            if (mRun == SC) begin
                mLevel = seen;
                mRise  = seen;
                mFall  = !seen;
                mRun   = 0;
            end
        end else begin
            if (mRun > 0 && mGlitch < 255) mGlitch++;
            mRun = 0;
        end
    endtask

    task automatic compareAll();
        checkOutput("btn_out", btn_out, mLevel);
        checkOutput("rise_pulse", rise_pulse, mRise);
        checkOutput("fall_pulse", fall_pulse, mFall);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkOutput("glitch_cnt", glitch_cnt, mGlitch);
`endif
    endtask

    // Called a little after a rising edge; drives btn_in, waits one edge, scores.
    task automatic applyStimulus(input logic b);
        btn_in = b;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
        riseSeen += int'(rise_pulse);
        fallSeen += int'(fall_pulse);
    endtask

    task automatic pulseReset(input int cycles);
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        compareAll();
        repeat (cycles) applyStimulus(btn_in);
        #1;
        reset = 1'b1;
    endtask

    // Holds btn_in at b and checks the matching strobe lands on edge 2+SC.
    task automatic measureEdge(input string tag, input logic b);
        bit found = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(b);
            if (!found && (b ? rise_pulse : fall_pulse)) begin
                checkOutput(tag, i, 2 + SC);
                found = 1'b1;
            end
        end
        if (!found) checkOutput({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int riseBefore;
        int seg;
        logic lvl;
        int len;

        // Reset held with btn_in high: outputs stay at reset values.
        reset  = 1'b0;
        btn_in = 1'b1;
        #1;
        modelReset();
        compareAll();
        repeat (5) applyStimulus(1'b1);
        #1;
        reset = 1'b1;
        measureEdge("rise_after_reset", 1'b1);

        // Clean low then clean rise.
        repeat (12) applyStimulus(1'b0);
        measureEdge("rise_latency", 1'b1);
        repeat (3) applyStimulus(1'b1);

        // Clean fall: fall strobe on edge 2+SC and no rise meanwhile.
        riseBefore = riseSeen;
        measureEdge("fall_latency", 1'b0);
        checkOutput("no_rise_on_fall", riseSeen - riseBefore, 0);

        // Two-cycle high pulse is rejected.
        repeat (6) applyStimulus(1'b0);
        riseBefore = riseSeen;
        repeat (2) applyStimulus(1'b1);
        repeat (10) applyStimulus(1'b0);
        checkOutput("short_pulse_rejected", riseSeen - riseBefore, 0);
        checkOutput("short_pulse_level", btn_out, 1'b0);

        // Bounce then steady high gives exactly one rise.
        riseBefore = riseSeen;
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        repeat (12) applyStimulus(1'b1);
        checkOutput("bounce_single_rise", riseSeen - riseBefore, 1);

        // Reset mid-qualification discards the pending rise, then re-qualifies it.
        repeat (12) applyStimulus(1'b0);
        repeat (4) applyStimulus(1'b1);
        riseBefore = riseSeen;
        pulseReset(3);
        checkOutput("reset_mid_wait_level", btn_out, 1'b0);
        checkOutput("reset_mid_wait_pulse", riseSeen - riseBefore, 0);
        measureEdge("rise_requalified", 1'b1);

        // Random segments with occasional asynchronous resets.
        for (seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 39) == 0) begin
                pulseReset(int'($urandom_range(1, 3)));
            end
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(SC + 2, SC + 8))
                                              : int'($urandom_range(1, SC + 1));
            repeat (len) applyStimulus(lvl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
